// File: rtl/nes_poll_sequencer.sv
// NES controller poller: latches the pad, clocks out eight serial bits and
// publishes the decoded button byte, either periodically or on request.
module nes_poll_sequencer #(
  parameter int HALF        = 300,
  parameter int POLL_PERIOD = 833333
) (
  input  logic       inputclk,
  input  logic       reset,
  input  logic       enable,
  input  logic       poll_req,
  input  logic       data,
  output logic       clklatch,
  output logic       clkout,
  output logic [7:0] buttons,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       valid,
  output logic       changed,
  output logic       busy
);

  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [10:0]   LATCH_LAST  = 11'(2 * HALF - 1);
  localparam logic [10:0]   BIT_LAST    = 11'(HALF - 1);

  typedef enum logic [2:0] {IDLE, LATCH, BIT_LO, BIT_HI, DONE} state_t;

  state_t        state_q;
  logic [10:0]   phase_q;
  logic [PW-1:0] period_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    buttons_q;
  logic [1:0]    sync_q;
  logic          clklatch_q;
  logic          clkout_q;
  logic          valid_q;
  logic          changed_q;

  always_ff @(posedge inputclk) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      period_q   <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      buttons_q  <= '0;
      sync_q     <= 2'b11;
      clklatch_q <= 1'b0;
      clkout_q   <= 1'b0;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], data};
      period_q  <= (period_q == PERIOD_LAST) ? '0 : period_q + 1'b1;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Triggers arriving outside IDLE are simply never looked at.
          if (enable && (period_q == PERIOD_LAST || poll_req)) begin
            state_q    <= LATCH;
            phase_q    <= '0;
            clklatch_q <= 1'b1;
            clkout_q   <= 1'b0;
          end
        end
        LATCH: begin
          if (phase_q == LATCH_LAST) begin
            state_q    <= BIT_LO;
            phase_q    <= '0;
            idx_q      <= '0;
            clklatch_q <= 1'b0;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        BIT_LO: begin
          if (phase_q == BIT_LAST) begin
            shift_q[idx_q] <= ~sync_q[1];
            state_q        <= BIT_HI;
            phase_q        <= '0;
            clkout_q       <= 1'b1;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        BIT_HI: begin
          if (phase_q == BIT_LAST) begin
            phase_q  <= '0;
            clkout_q <= 1'b0;
            if (idx_q == 3'd7) begin
              // Publish in the same edge that enters DONE so valid and
              // buttons are visible together for the single DONE cycle.
              state_q   <= DONE;
              buttons_q <= shift_q;
              valid_q   <= 1'b1;
              changed_q <= (shift_q != buttons_q);
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= BIT_LO;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign clklatch = clklatch_q;
  assign clkout   = clkout_q;
  assign buttons  = buttons_q;
  assign up       = buttons_q[4];
  assign down     = buttons_q[5];
  assign left     = buttons_q[6];
  assign right    = buttons_q[7];
  assign valid    = valid_q;
  assign changed  = changed_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_nes_poll_sequencer.sv
// Directed bench for nes_poll_sequencer with HALF=4, POLL_PERIOD=100 and a
// behavioural NES pad driving the serial data line.
module tb_nes_poll_sequencer;

  logic       clk = 1'b0;
  logic       reset, enable, poll_req, data;
  logic       clklatch, clkout, up, down, left, right, valid, changed, busy;
  logic [7:0] buttons;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] pressed = 8'h00;
  int         bitpos = 8;
  logic       clkout_prev = 1'b0;

  nes_poll_sequencer #(.HALF(4), .POLL_PERIOD(100)) dut (
    .inputclk(clk), .reset(reset), .enable(enable), .poll_req(poll_req),
    .data(data), .clklatch(clklatch), .clkout(clkout), .buttons(buttons),
    .up(up), .down(down), .left(left), .right(right),
    .valid(valid), .changed(changed), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; then update the pad model (latch reloads, clkout rise shifts).
  task automatic step();
    @(posedge clk);
    #1;
    if (clklatch) bitpos = 0;
    else if (clkout && !clkout_prev && bitpos < 8) bitpos++;
    clkout_prev = clkout;
    data = (bitpos < 8) ? ~pressed[bitpos] : 1'b1;
  endtask

  task automatic wait_latch(input string tag, input int exp);
    int w = 0;
    do begin
      step();
      w++;
    end while (!clklatch && w < exp + 20);
    check_vec(tag, w, exp);
  endtask

  task automatic idle_watch(input string tag, input int n);
    int hits = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (clklatch || busy) hits++;
    end
    check_vec(tag, hits, 0);
  endtask

  // Entered with clklatch just seen high (k=0); walks to k=73.
  // Optional injections: poll_req at req_k, enable drop at en_k, reset at rst_k.
  task automatic check_poll(input string tag, input logic [7:0] old_btn,
                            input logic [7:0] exp_btn, input logic exp_chg,
                            input int req_k, input int en_k, input int rst_k);
    logic [3:0] exp_w;
    for (int k = 0; k <= 73; k++) begin
      exp_w = {k < 8, (k >= 8 && k < 72 && ((k - 8) % 8) >= 4), k <= 72, k == 72};
      check_vec($sformatf("%s wave k=%0d", tag, k), {clklatch, clkout, busy, valid}, exp_w);
      if (k < 72)
        check_vec($sformatf("%s hold k=%0d", tag, k), buttons, old_btn);
      if (k == 72) begin
        check_vec({tag, " buttons"}, buttons, exp_btn);
        check_vec({tag, " changed"}, changed, exp_chg);
        check_vec({tag, " dirs"}, {up, down, left, right},
                  {exp_btn[4], exp_btn[5], exp_btn[6], exp_btn[7]});
      end
      if (k == 73) break;
      if (k == rst_k) begin
        reset = 1'b1;
        step();
        check_vec({tag, " abort"}, {clklatch, clkout, valid, changed, busy, buttons}, 0);
        reset = 1'b0;
        return;
      end
      if (k == en_k) enable = 1'b0;
      if (k == req_k) poll_req = 1'b1;
      step();
      poll_req = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; poll_req = 1'b0; data = 1'b1;
    repeat (3) step();
    check_vec("reset state", {clklatch, clkout, valid, changed, busy, buttons}, 0);

    // Automatic poll after release, nothing pressed.
    reset = 1'b0;
    wait_latch("first auto latch", 100);
    check_poll("auto0", 8'h00, 8'h00, 1'b0, -1, -1, -1);

    // Requested poll with A and Up pressed.
    pressed = 8'h11;
    poll_req = 1'b1;
    step();
    poll_req = 1'b0;
    check_vec("req latency", clklatch, 1'b1);
    check_poll("reqAUp", 8'h00, 8'h11, 1'b1, -1, -1, -1);

    // Identical poll with an extra request mid-poll, which must be dropped.
    poll_req = 1'b1;
    step();
    poll_req = 1'b0;
    check_poll("repeat", 8'h11, 8'h11, 1'b0, 10, -1, -1);
    idle_watch("no queued poll", 20);

    // Next scheduled poll, aborted by reset at the 3rd clkout pulse.
    wait_latch("sched latch", 59);
    check_poll("abort", 8'h11, 8'h11, 1'b0, -1, -1, 28);
    wait_latch("post-reset latch", 100);
    check_poll("after rst", 8'h00, 8'h11, 1'b1, -1, -1, -1);

    // Enable dropped during BIT_LO of bit 2: poll finishes, then silence.
    pressed = 8'h80;
    wait_latch("en latch", 27);
    check_poll("endrop", 8'h11, 8'h80, 1'b1, -1, 25, -1);
    idle_watch("disabled idle", 250);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
